// File: rtl/hpdcache_mem_responder.sv
// hpdcache_mem_responder
//   Memory-side responder for the HPDcache memory interface. It accepts read
//   and write requests, stores write beats into an internal word-addressed RAM
//   (DepthWords entries of MemDataWidth bits) and returns read beats from it.
//   Read and write channels are independent FSMs.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   mem_req_read_*                 read request channel   (target)
//   mem_resp_read_*                read beat channel      (initiator)
//   mem_req_write_*                write request channel  (target)
//   mem_req_write_data_*           write beat channel     (target)
//   mem_resp_write_*               write response channel (initiator)
//
// Configuration
//   HPDCACHE_MEM_RESPONDER_ERR_EN  when defined, non-zero address bits above
//   the RAM index range flag the transaction as out-of-range: reads return
//   zero data with error=1, writes are discarded and answered with error=1.
//   When undefined, upper address bits alias and error is always 0.

package hpdcache_mem_responder_pkg;
  typedef struct packed {
    logic [55:0] mem_req_addr;
    logic [7:0]  mem_req_len;
    logic [2:0]  mem_req_size;
    logic [5:0]  mem_req_id;
    logic [1:0]  mem_req_command;
    logic [3:0]  mem_req_atomic;
    logic        mem_req_cacheable;
  } mem_req_t;

  typedef struct packed {
    logic [511:0] mem_req_w_data;
    logic [63:0]  mem_req_w_be;
    logic         mem_req_w_last;
  } mem_req_w_t;

  typedef struct packed {
    logic         mem_resp_r_error;
    logic [5:0]   mem_resp_r_id;
    logic [511:0] mem_resp_r_data;
    logic         mem_resp_r_last;
  } mem_resp_r_t;

  typedef struct packed {
    logic       mem_resp_w_is_atomic;
    logic       mem_resp_w_error;
    logic [5:0] mem_resp_w_id;
  } mem_resp_w_t;
endpackage

module hpdcache_mem_responder #(
  parameter int unsigned MemAddrWidth = 56,
  parameter int unsigned MemIdWidth   = 6,
  parameter int unsigned MemDataWidth = 512,
  parameter int unsigned DepthWords   = 256,
  parameter int unsigned ReadLatency  = 2,
  parameter type mem_req_t    = hpdcache_mem_responder_pkg::mem_req_t,
  parameter type mem_req_w_t  = hpdcache_mem_responder_pkg::mem_req_w_t,
  parameter type mem_resp_r_t = hpdcache_mem_responder_pkg::mem_resp_r_t,
  parameter type mem_resp_w_t = hpdcache_mem_responder_pkg::mem_resp_w_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_read_ready_o,
  input  logic        mem_req_read_valid_i,
  input  mem_req_t    mem_req_read_i,
  input  logic        mem_resp_read_ready_i,
  output logic        mem_resp_read_valid_o,
  output mem_resp_r_t mem_resp_read_o,
  output logic        mem_req_write_ready_o,
  input  logic        mem_req_write_valid_i,
  input  mem_req_t    mem_req_write_i,
  output logic        mem_req_write_data_ready_o,
  input  logic        mem_req_write_data_valid_i,
  input  mem_req_w_t  mem_req_write_data_i,
  input  logic        mem_resp_write_ready_i,
  output logic        mem_resp_write_valid_o,
  output mem_resp_w_t mem_resp_write_o
);

  localparam int BeBytes = int'(MemDataWidth / 8);
  localparam int OffW    = $clog2(BeBytes);
  localparam int IdxW    = $clog2(DepthWords);
  localparam int WaitW   = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  logic [MemDataWidth-1:0] ram [DepthWords];

  logic [MemAddrWidth-1:0] raddr, waddr;
  logic                    rd_oor, wr_oor;
  logic                    unused_bits;

  assign raddr = mem_req_read_i.mem_req_addr;
  assign waddr = mem_req_write_i.mem_req_addr;

`ifdef HPDCACHE_MEM_RESPONDER_ERR_EN
  assign rd_oor = |raddr[MemAddrWidth-1:OffW+IdxW];
  assign wr_oor = |waddr[MemAddrWidth-1:OffW+IdxW];
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif

  // size, command, atomic and cacheable fields do not affect behaviour
  assign unused_bits = ^{mem_req_read_i, mem_req_write_i, raddr, waddr};

  // ---------------- read channel ----------------
  rstate_e                 rstate, rstate_nxt;
  logic [IdxW-1:0]         ridx, ridx_inc;
  logic [7:0]              rleft;
  logic [WaitW-1:0]        rwait;
  logic [MemIdWidth-1:0]   rid;
  logic                    rerr;
  logic [MemDataWidth-1:0] rdata;
  logic                    rd_last;

  assign ridx_inc = ridx + IdxW'(1);
  assign rd_last  = (rleft == '0);

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (mem_req_read_valid_i) rstate_nxt = R_WAIT;
      R_WAIT:  if (rwait == '0) rstate_nxt = R_BURST;
      R_BURST: if (mem_resp_read_ready_i && rd_last) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Beat data is captured into rdata on the edge that starts presenting the
  // beat, so it stays stable across stalls and a same-edge RAM write to that
  // index is not seen (read-first).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rstate <= R_IDLE;
      ridx   <= '0;
      rleft  <= '0;
      rwait  <= '0;
      rid    <= '0;
      rerr   <= 1'b0;
      rdata  <= '0;
    end else begin
      rstate <= rstate_nxt;
      case (rstate)
        R_IDLE: begin
          if (mem_req_read_valid_i) begin
            ridx  <= raddr[OffW +: IdxW];
            rid   <= mem_req_read_i.mem_req_id;
            rleft <= mem_req_read_i.mem_req_len;
            rwait <= WaitW'(ReadLatency - 1);
            rerr  <= rd_oor;
          end
        end
        R_WAIT: begin
          if (rwait != '0) rwait <= rwait - WaitW'(1);
          else             rdata <= rerr ? '0 : ram[ridx];
        end
        R_BURST: begin
          if (mem_resp_read_ready_i && !rd_last) begin
            ridx  <= ridx_inc;
            rleft <= rleft - 8'd1;
            rdata <= rerr ? '0 : ram[ridx_inc];
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_read_ready_o  = (rstate == R_IDLE);
  assign mem_resp_read_valid_o = (rstate == R_BURST);

  always_comb begin
    mem_resp_read_o                  = '0;
    mem_resp_read_o.mem_resp_r_error = rerr;
    mem_resp_read_o.mem_resp_r_id    = rid;
    mem_resp_read_o.mem_resp_r_data  = rdata;
    mem_resp_read_o.mem_resp_r_last  = (rstate == R_BURST) && rd_last;
  end

  // ---------------- write channel ----------------
  wstate_e               wstate, wstate_nxt;
  logic [IdxW-1:0]       widx;
  logic [MemIdWidth-1:0] wid;
  logic                  werr;
  logic                  wr_beat_acc;

  assign wr_beat_acc = (wstate == W_DATA) && mem_req_write_data_valid_i;

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (mem_req_write_valid_i) wstate_nxt = W_DATA;
      W_DATA:  if (wr_beat_acc && mem_req_write_data_i.mem_req_w_last) wstate_nxt = W_RESP;
      W_RESP:  if (mem_resp_write_ready_i) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wstate <= W_IDLE;
      widx   <= '0;
      wid    <= '0;
      werr   <= 1'b0;
    end else begin
      wstate <= wstate_nxt;
      if (wstate == W_IDLE && mem_req_write_valid_i) begin
        widx <= waddr[OffW +: IdxW];
        wid  <= mem_req_write_i.mem_req_id;
        werr <= wr_oor;
      end else if (wr_beat_acc) begin
        widx <= widx + IdxW'(1);
      end
    end
  end

  // RAM is never cleared; out-of-range write beats are dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_beat_acc && !werr) begin
      for (int b = 0; b < BeBytes; b++) begin
        if (mem_req_write_data_i.mem_req_w_be[b])
          ram[widx][b*8 +: 8] <= mem_req_write_data_i.mem_req_w_data[b*8 +: 8];
      end
    end
  end

  assign mem_req_write_ready_o      = (wstate == W_IDLE);
  assign mem_req_write_data_ready_o = (wstate == W_DATA);
  assign mem_resp_write_valid_o     = (wstate == W_RESP);

  always_comb begin
    mem_resp_write_o                      = '0;
    mem_resp_write_o.mem_resp_w_is_atomic = 1'b0;
    mem_resp_write_o.mem_resp_w_error     = werr;
    mem_resp_write_o.mem_resp_w_id        = wid;
  end

endmodule

// File: tb/tb_hpdcache_mem_responder.sv
// Testbench for hpdcache_mem_responder: transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_hpdcache_mem_responder;
  import hpdcache_mem_responder_pkg::*;

  localparam int D  = 256;
  localparam int RL = 2;
`ifdef HPDCACHE_MEM_RESPONDER_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rreq_ready, rreq_valid, rresp_ready, rresp_valid;
  mem_req_t    rreq;
  mem_resp_r_t rresp;
  logic        wreq_ready, wreq_valid, wdat_ready, wdat_valid, wresp_ready, wresp_valid;
  mem_req_t    wreq;
  mem_req_w_t  wdat;
  mem_resp_w_t wresp;

  always #5 clk = ~clk;

  hpdcache_mem_responder dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .mem_req_read_ready_o       (rreq_ready),
    .mem_req_read_valid_i       (rreq_valid),
    .mem_req_read_i             (rreq),
    .mem_resp_read_ready_i      (rresp_ready),
    .mem_resp_read_valid_o      (rresp_valid),
    .mem_resp_read_o            (rresp),
    .mem_req_write_ready_o      (wreq_ready),
    .mem_req_write_valid_i      (wreq_valid),
    .mem_req_write_i            (wreq),
    .mem_req_write_data_ready_o (wdat_ready),
    .mem_req_write_data_valid_i (wdat_valid),
    .mem_req_write_data_i       (wdat),
    .mem_resp_write_ready_i     (wresp_ready),
    .mem_resp_write_valid_o     (wresp_valid),
    .mem_resp_write_o           (wresp)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [511:0] mram [D];
  bit           started = 0;
  bit           r_busy, r_pres, r_err;
  int           r_cnt, r_n, r_len, r_idx;
  logic [5:0]   r_id;
  logic [511:0] r_data;
  int           w_mode, w_idx;
  logic [5:0]   w_id;
  bit           w_err;

  function automatic bit oor(input logic [55:0] a);
    return ErrEn && ((a >> 14) != 0);
  endfunction

  function automatic logic [511:0] beat_of(input int i);
    return r_err ? '0 : mram[i % D];
  endfunction

  task automatic model_step();
    cyc++;
    if (rst) begin
      started = 1; r_busy = 0; r_pres = 0; w_mode = 0;
    end else begin
      // read side first: beat data comes from memory as it was before this edge
      if (r_pres) begin
        if (rresp_ready) begin
          if (r_n == r_len) begin r_pres = 0; r_busy = 0; end
          else begin r_n++; r_data = beat_of(r_idx + r_n); end
        end
      end else if (r_busy) begin
        r_cnt--;
        if (r_cnt == 0) begin r_pres = 1; r_data = beat_of(r_idx); end
      end else if (rreq_valid) begin
        r_busy = 1; r_cnt = RL; r_n = 0;
        r_id   = rreq.mem_req_id;
        r_idx  = int'((rreq.mem_req_addr / 64) % D);
        r_len  = int'(rreq.mem_req_len);
        r_err  = oor(rreq.mem_req_addr);
      end
      case (w_mode)
        0: if (wreq_valid) begin
             w_mode = 1; w_id = wreq.mem_req_id;
             w_idx  = int'((wreq.mem_req_addr / 64) % D);
             w_err  = oor(wreq.mem_req_addr);
           end
        1: if (wdat_valid) begin
             if (!w_err)
               for (int b = 0; b < 64; b++)
                 if (wdat.mem_req_w_be[b]) mram[w_idx][b*8 +: 8] = wdat.mem_req_w_data[b*8 +: 8];
             w_idx = (w_idx + 1) % D;
             if (wdat.mem_req_w_last) w_mode = 2;
           end
        default: if (wresp_ready) w_mode = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("rd_req_ready", rreq_ready, !r_busy);
      chk("rd_valid", rresp_valid, r_pres);
      if (r_pres) begin
        chk("rd_data", rresp.mem_resp_r_data, r_data);
        chk("rd_id", rresp.mem_resp_r_id, r_id);
        chk("rd_last", rresp.mem_resp_r_last, r_n == r_len);
        chk("rd_error", rresp.mem_resp_r_error, r_err);
      end
      chk("wr_req_ready", wreq_ready, w_mode == 0);
      chk("wr_data_ready", wdat_ready, w_mode == 1);
      chk("wr_resp_valid", wresp_valid, w_mode == 2);
      if (w_mode == 2) begin
        chk("wr_resp_id", wresp.mem_resp_w_id, w_id);
        chk("wr_resp_error", wresp.mem_resp_w_error, w_err);
        chk("wr_resp_atomic", wresp.mem_resp_w_is_atomic, 1'b0);
      end
    end
  end

  // ---------------- drivers ----------------
  int           racc;
  int           bfirst;
  logic [511:0] bdat [8];
  bit           blast [8];
  bit           berr [8];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd_req(input logic [5:0] id, input logic [55:0] addr, input logic [7:0] len);
    bit acc = 0;
    rreq = '0; rreq.mem_req_id = id; rreq.mem_req_addr = addr; rreq.mem_req_len = len;
    rreq.mem_req_size = 3'd6; rreq_valid = 1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = rreq_ready;
      step();
    end
    rreq_valid = 0;
    racc = cyc;
    chk("rd_req_accepted", acc, 1'b1);
  endtask

  task automatic rd_collect(input int n, input bit toggle);
    int got = 0;
    bit ph = 1;
    bfirst = -1;
    for (int t = 0; t < 200 && got < n; t++) begin
      rresp_ready = toggle ? ph : 1'b1;
      ph = !ph;
      @(negedge clk);
      if (rresp_valid && bfirst < 0) bfirst = cyc;
      if (rresp_valid && rresp_ready) begin
        bdat[got]  = rresp.mem_resp_r_data;
        blast[got] = rresp.mem_resp_r_last;
        berr[got]  = rresp.mem_resp_r_error;
        got++;
      end
      step();
    end
    rresp_ready = 0;
    chk("rd_beat_count", got, n);
  endtask

  task automatic wr_req(input logic [5:0] id, input logic [55:0] addr, input logic [7:0] len);
    bit acc = 0;
    wreq = '0; wreq.mem_req_id = id; wreq.mem_req_addr = addr; wreq.mem_req_len = len;
    wreq.mem_req_size = 3'd6; wreq_valid = 1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = wreq_ready;
      step();
    end
    wreq_valid = 0;
    chk("wr_req_accepted", acc, 1'b1);
  endtask

  task automatic wr_beat(input logic [511:0] data, input logic [63:0] be, input bit last);
    bit acc = 0;
    wdat.mem_req_w_data = data; wdat.mem_req_w_be = be; wdat.mem_req_w_last = last;
    wdat_valid = 1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = wdat_ready;
      step();
    end
    wdat_valid = 0;
    chk("wr_beat_accepted", acc, 1'b1);
  endtask

  task automatic wr_resp(input logic [5:0] id, input bit err);
    bit seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (wresp_valid) begin
        seen = 1;
        chk("wr_resp_id_lit", wresp.mem_resp_w_id, id);
        chk("wr_resp_err_lit", wresp.mem_resp_w_error, err);
      end
      step();
    end
    chk("wr_resp_seen", seen, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rreq = '0; wreq = '0; wdat = '0;
    rreq_valid = 0; rresp_ready = 0; wreq_valid = 0; wdat_valid = 0; wresp_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    @(negedge clk);
    chk("rst_rd_valid", rresp_valid, 1'b0);
    chk("rst_rd_payload", rresp, '0);
    chk("rst_wr_valid", wresp_valid, 1'b0);
    chk("rst_wr_payload", wresp, '0);
    chk("rst_rd_ready", rreq_ready, 1'b1);
    step();

    // preload indices 254,255,0,1 with a wrapping 4-beat burst
    wr_req(6'd1, 56'd16256, 8'd3);
    for (int k = 0; k < 4; k++) wr_beat({16{32'hC0DE0000 + 32'(k)}}, '1, k == 3);
    wr_resp(6'd1, 1'b0);

    // single-beat write to index 1
    wr_req(6'd5, 56'h40, 8'd0);
    wr_beat({64{8'hA5}}, '1, 1'b1);
    wr_resp(6'd5, 1'b0);

    // single-beat read: first beat exactly two cycles after acceptance
    rd_req(6'd3, 56'h40, 8'd0);
    rd_collect(1, 1'b0);
    chk("rd_latency", bfirst - racc, 2);
    chk("rd1_data", bdat[0], {64{8'hA5}});
    chk("rd1_last", blast[0], 1'b1);

    // wrapping burst with a stalling consumer
    rd_req(6'd7, 56'd16256, 8'd3);
    rd_collect(4, 1'b1);
    chk("wrap_b0", bdat[0], {16{32'hC0DE0000}});
    chk("wrap_b1", bdat[1], {16{32'hC0DE0001}});
    chk("wrap_b2", bdat[2], {16{32'hC0DE0002}});
    chk("wrap_b3", bdat[3], {64{8'hA5}});
    chk("wrap_lasts", {blast[0], blast[1], blast[2], blast[3]}, 4'b0001);

    // partial byte enables
    wr_req(6'd2, 56'h280, 8'd0);
    wr_beat({64{8'h11}}, '1, 1'b1);
    wr_resp(6'd2, 1'b0);
    wr_req(6'd4, 56'h280, 8'd1);
    wr_beat({64{8'hEE}}, 64'h0F, 1'b0);
    wr_beat({64{8'h77}}, '1, 1'b1);
    wr_resp(6'd4, 1'b0);
    rd_req(6'd8, 56'h280, 8'd1);
    rd_collect(2, 1'b0);
    chk("be_b0", bdat[0], {{60{8'h11}}, {4{8'hEE}}});
    chk("be_b1", bdat[1], {64{8'h77}});

    // reset while beat 2 of 4 is presented
    rd_req(6'd9, 56'd16256, 8'd3);
    rd_collect(1, 1'b0);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("mid_rst_rd_valid", rresp_valid, 1'b0);
    chk("mid_rst_rd_ready", rreq_ready, 1'b1);
    step();
    rd_req(6'd3, 56'h40, 8'd0);
    rd_collect(1, 1'b0);
    chk("post_rst_data", bdat[0], {64{8'hA5}});

    if (ErrEn) begin
      rd_req(6'd10, 56'h1 << 40, 8'd1);
      rd_collect(2, 1'b0);
      chk("err_rd_b0", {berr[0], bdat[0]}, {1'b1, 512'd0});
      chk("err_rd_b1", {berr[1], bdat[1]}, {1'b1, 512'd0});
      wr_req(6'd11, 56'h1 << 40, 8'd0);
      wr_beat({64{8'h5A}}, '1, 1'b1);
      wr_resp(6'd11, 1'b1);
      rd_req(6'd12, 56'h0, 8'd0);
      rd_collect(1, 1'b0);
      chk("err_ram_kept", bdat[0], {16{32'hC0DE0002}});
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
